// File: rtl/harvard_cpu_wrapper.sv
// 8-bit multi-cycle Harvard CPU: 256x8 instruction ROM, 256x8 data RAM,
// four 8-bit registers, N/Z/C flags, IO register and an LED/debug output mux.
module harvard_cpu_wrapper #(
  parameter string IMEM_INIT = "imem.mem",
  parameter string DMEM_INIT = ""
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       carry_in,
  input  logic       led_driver_flag,
  input  logic       rd_addr_flag,
  input  logic [7:0] rd_addr,
  output logic [7:0] led_driver
);

  typedef enum logic [3:0] {
    S_F0, S_F1, S_F2, S_DEC, S_EX, S_WB, S_I0, S_I1, S_I2, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    OP_NOOP = 4'h0, OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NEG,
    OP_NOT, OP_WR, OP_RD, OP_WRIO, OP_JMP, OP_JMPZ, OP_JMPN, OP_BRK
  } op_e;

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] imm_q, imm_d;
  logic [7:0] res_q, res_d;
  logic [7:0] io_reg_q, io_reg_d;
  logic       flag_n_q, flag_n_d;
  logic       flag_z_q, flag_z_d;
  logic       flag_c_q, flag_c_d;
  logic [7:0] regs_q [4];

  logic       rf_we;
  logic [1:0] rf_wsel;
  logic [7:0] rf_wdata;
  logic [3:0] rf_we_vec;

  op_e        op;
  logic [1:0] ra, rb;
  logic [7:0] ra_val, rb_val;
  logic       is_alu_op;
  logic       halted;

  logic [8:0] alu_full;
  logic [7:0] alu_res;
  logic       alu_c;

  logic [7:0] imem_mem [256];
  logic [7:0] imem_q;
  logic [7:0] dmem_mem [256];
  logic [7:0] dmem_q;
  logic [7:0] dmem_addr;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_we;
  logic       dmem_we;

  // Data RAM powers up as all zeros; the instruction ROM is preloaded externally.
  initial begin
    for (int i = 0; i < 256; i++) dmem_mem[i] = 8'h00;
  end

  assign op        = op_e'(ir_q[7:4]);
  assign ra        = ir_q[3:2];
  assign rb        = ir_q[1:0];
  assign ra_val    = regs_q[ra];
  assign rb_val    = regs_q[rb];
  assign is_alu_op = (op >= OP_ADD) && (op <= OP_NOT);
  assign halted    = (state_q == S_HALT);

  // Bit 8 carries the ADD carry-out or the SUB borrow; zero for logic ops.
  always_comb begin
    alu_full = 9'd0;
    case (op)
      OP_ADD:  alu_full = {1'b0, ra_val} + {1'b0, rb_val} + {8'd0, carry_in};
      OP_SUB:  alu_full = {1'b0, ra_val} - {1'b0, rb_val};
      OP_AND:  alu_full = {1'b0, ra_val & rb_val};
      OP_OR:   alu_full = {1'b0, ra_val | rb_val};
      OP_XOR:  alu_full = {1'b0, ra_val ^ rb_val};
      OP_NEG:  alu_full = {1'b0, 8'd0 - ra_val};
      OP_NOT:  alu_full = {1'b0, ~ra_val};
      default: alu_full = 9'd0;
    endcase
  end

  assign alu_res = alu_full[7:0];
  assign alu_c   = alu_full[8];

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    imm_d     = imm_q;
    res_d     = res_q;
    io_reg_d  = io_reg_q;
    flag_n_d  = flag_n_q;
    flag_z_d  = flag_z_q;
    flag_c_d  = flag_c_q;
    rf_we     = 1'b0;
    rf_wsel   = ra;
    rf_wdata  = 8'h00;
    cpu_addr  = 8'h00;
    cpu_wdata = 8'h00;
    cpu_we    = 1'b0;
    case (state_q)
      S_F0: state_d = S_F1;
      S_F1: state_d = S_F2;
      S_F2: begin
        ir_d    = imem_q;
        pc_d    = pc_q + 8'd1;
        state_d = S_DEC;
      end
      S_DEC: begin
        case (op)
          OP_NOOP:                         state_d = S_F0;
          OP_BRK:                          state_d = S_HALT;
          OP_LD, OP_JMP, OP_JMPZ, OP_JMPN: state_d = S_I0;
          default:                         state_d = S_EX;
        endcase
      end
      S_EX: begin
        state_d = S_WB;
        if (is_alu_op) begin
          res_d    = alu_res;
          flag_n_d = alu_res[7];
          flag_z_d = (alu_res == 8'h00);
          flag_c_d = alu_c;
        end else if (op == OP_WR) begin
          cpu_addr  = rb_val;
          cpu_wdata = ra_val;
          cpu_we    = 1'b1;
          state_d   = S_F0;
        end else if (op == OP_RD) begin
          cpu_addr = rb_val;
        end else begin
          cpu_addr = ra_val;
        end
      end
      S_I0: state_d = S_I1;
      S_I1: state_d = S_I2;
      S_I2: begin
        imm_d   = imem_q;
        pc_d    = pc_q + 8'd1;
        state_d = S_WB;
      end
      S_WB: begin
        state_d = S_F0;
        case (op)
          OP_LD: begin
            rf_we    = 1'b1;
            rf_wdata = imm_q;
          end
          OP_RD: begin
            rf_we    = 1'b1;
            rf_wdata = dmem_q;
          end
          OP_WRIO: io_reg_d = dmem_q;
          OP_JMP:  pc_d = imm_q;
          OP_JMPZ: if (flag_z_q) pc_d = imm_q;
          OP_JMPN: if (flag_n_q) pc_d = imm_q;
          default: begin
            rf_we    = is_alu_op;
            rf_wdata = res_q;
          end
        endcase
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_F0;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rf_dec
      assign rf_we_vec[gi] = rf_we && (rf_wsel == 2'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_F0;
      pc_q     <= 8'h00;
      ir_q     <= 8'h00;
      imm_q    <= 8'h00;
      res_q    <= 8'h00;
      io_reg_q <= 8'h00;
      flag_n_q <= 1'b0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
      for (int i = 0; i < 4; i++) regs_q[i] <= 8'h00;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      imm_q    <= imm_d;
      res_q    <= res_d;
      io_reg_q <= io_reg_d;
      flag_n_q <= flag_n_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
      for (int i = 0; i < 4; i++) begin
        if (rf_we_vec[i]) regs_q[i] <= rf_wdata;
      end
    end
  end

  // The ROM is always addressed by PC; its read port idles while halted.
  always_ff @(posedge clk) begin
    if (!halted) imem_q <= imem_mem[pc_q];
  end

  // Debug reads steal the RAM port and suppress any CPU write in that cycle.
  assign dmem_addr = rd_addr_flag ? rd_addr : cpu_addr;
  assign dmem_we   = cpu_we && !rd_addr_flag && !rst;

  always @(posedge clk) begin
    if (dmem_we) dmem_mem[dmem_addr] <= cpu_wdata;
    dmem_q <= dmem_mem[dmem_addr];
  end

  assign led_driver = rd_addr_flag    ? dmem_q   :
                      led_driver_flag ? io_reg_q : 8'h00;

endmodule

// File: tb/tb_harvard_cpu_wrapper.sv
// Directed bench: an instruction-level model predicts architectural state and
// cycle counts; expectations queue in a scoreboard and pop as the DUT is sampled.
module tb_harvard_cpu_wrapper;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       carry_in = 1'b0;
  logic       led_driver_flag = 1'b0;
  logic       rd_addr_flag = 1'b0;
  logic [7:0] rd_addr = 8'h00;
  logic [7:0] led_driver;

  always #5 clk = ~clk;

  harvard_cpu_wrapper #(.IMEM_INIT(""), .DMEM_INIT("")) dut (
    .clk             (clk),
    .rst             (rst),
    .carry_in        (carry_in),
    .led_driver_flag (led_driver_flag),
    .rd_addr_flag    (rd_addr_flag),
    .rd_addr         (rd_addr),
    .led_driver      (led_driver)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t   sb_q[$];
  int         tests_run = 0;
  int         tests_failed = 0;

  logic [7:0] prog_q[$];
  logic [7:0] rom [256];
  logic [7:0] m_r [4];
  logic [7:0] m_dmem [256];
  logic [7:0] m_io, m_pc;
  logic       m_n, m_z, m_c;
  int         m_cycles;

  task automatic push_exp(input string tag, input logic [31:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.exp = exp;
    sb_q.push_back(it);
  endtask

  task automatic check_obs(input logic [31:0] obs);
    sb_item_t it;
    tests_run++;
    if (sb_q.size() == 0) begin
      tests_failed++;
      $error("FAIL scoreboard_empty: observed %0h expected none", obs);
    end else begin
      it = sb_q.pop_front();
      assert (obs === it.exp) else begin
        tests_failed++;
        $error("FAIL %s: observed %0h expected %0h", it.tag, obs, it.exp);
      end
    end
  endtask

  task automatic load_prog(input logic [7:0] fill);
    for (int i = 0; i < 256; i++) begin
      rom[i] = (i < prog_q.size()) ? prog_q[i] : fill;
      dut.imem_mem[i] = rom[i];
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_n = 1'b0; m_z = 1'b0; m_c = 1'b0;
    m_io = 8'h00; m_pc = 8'h00;
  endtask

  // Executes whole instructions from the bench ROM copy until BRK.
  task automatic model_run(input logic cin);
    logic [7:0] ir, a, b, res, imm;
    logic [8:0] t9;
    logic [3:0] op;
    logic [1:0] ra, rb;
    bit         done;
    m_cycles = 0;
    done = 1'b0;
    for (int n = 0; n < 4000 && !done; n++) begin
      ir = rom[m_pc];
      m_pc = m_pc + 8'd1;
      op = ir[7:4]; ra = ir[3:2]; rb = ir[1:0];
      a = m_r[ra]; b = m_r[rb];
      case (op)
        4'h0: m_cycles += 4;
        4'h1, 4'hC, 4'hD, 4'hE: begin
          imm = rom[m_pc];
          m_pc = m_pc + 8'd1;
          m_cycles += 8;
          if (op == 4'h1) m_r[ra] = imm;
          else if (op == 4'hC || (op == 4'hD && m_z) || (op == 4'hE && m_n)) m_pc = imm;
        end
        4'h9: begin m_dmem[b] = a; m_cycles += 5; end
        4'hA: begin m_r[ra] = m_dmem[b]; m_cycles += 6; end
        4'hB: begin m_io = m_dmem[a]; m_cycles += 6; end
        4'hF: begin m_cycles += 4; done = 1'b1; end
        default: begin
          case (op)
            4'h2:    t9 = {1'b0, a} + {1'b0, b} + {8'd0, cin};
            4'h3:    t9 = {1'b0, a} - {1'b0, b};
            4'h4:    t9 = {1'b0, a & b};
            4'h5:    t9 = {1'b0, a | b};
            4'h6:    t9 = {1'b0, a ^ b};
            4'h7:    t9 = {1'b0, 8'h00 - a};
            default: t9 = {1'b0, ~a};
          endcase
          res = t9[7:0];
          m_n = res[7]; m_z = (res == 8'h00); m_c = t9[8];
          m_r[ra] = res;
          m_cycles += 6;
        end
      endcase
    end
  endtask

  task automatic push_arch(input string tag);
    push_exp({tag, " halted"}, 32'd1);
    for (int i = 0; i < 4; i++) push_exp($sformatf("%s r%0d", tag, i), 32'(m_r[i]));
    push_exp({tag, " n"}, 32'(m_n));
    push_exp({tag, " z"}, 32'(m_z));
    push_exp({tag, " c"}, 32'(m_c));
    push_exp({tag, " io"}, 32'(m_io));
    push_exp({tag, " pc"}, 32'(m_pc));
  endtask

  task automatic check_arch();
    check_obs(32'(dut.halted));
    for (int i = 0; i < 4; i++) check_obs(32'(dut.regs_q[i]));
    check_obs(32'(dut.flag_n_q));
    check_obs(32'(dut.flag_z_q));
    check_obs(32'(dut.flag_c_q));
    check_obs(32'(dut.io_reg_q));
    check_obs(32'(dut.pc_q));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_to_halt(output int cyc, output bit wrapped);
    logic [7:0] prev;
    cyc = 0;
    wrapped = 1'b0;
    prev = dut.pc_q;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      if (prev == 8'hFF && dut.pc_q == 8'h00) wrapped = 1'b1;
      prev = dut.pc_q;
    end while (!dut.halted && cyc < 3000);
  endtask

  task automatic dbg_read(input logic [7:0] addr, output logic [7:0] val);
    @(negedge clk);
    rd_addr = addr;
    rd_addr_flag = 1'b1;
    @(negedge clk);
    val = led_driver;
    rd_addr_flag = 1'b0;
  endtask

  task automatic led_io(output logic [7:0] val);
    @(negedge clk);
    rd_addr_flag = 1'b0;
    led_driver_flag = 1'b1;
    @(negedge clk);
    val = led_driver;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int         cyc;
    bit         wrapped;
    logic [7:0] v;
    for (int i = 0; i < 256; i++) m_dmem[i] = 8'h00;

    // T1: 34+48 stored at dmem[1], then copied to the IO register.
    prog_q = '{8'h10, 8'h34, 8'h14, 8'h48, 8'h1C, 8'h01, 8'h21, 8'h93, 8'hBC, 8'hF0};
    load_prog(8'hF0);
    carry_in = 1'b0;
    model_reset();
    model_run(1'b0);
    push_exp("t1 cycles", 32'(m_cycles));
    push_arch("t1");
    push_exp("t1 io led", 32'h7C);
    push_exp("t1 dbg dmem1", 32'h7C);
    do_reset();
    run_to_halt(cyc, wrapped);
    $display("[TB] t1 run: %0d cycles to halt", cyc);
    check_obs(32'(cyc));
    check_arch();
    led_io(v);            check_obs(32'(v));
    dbg_read(8'h01, v);   check_obs(32'(v));

    // T5: reset while ADD sits in write-back; R0 must not be written.
    push_exp("t5 pre r0", 32'h34);
    push_exp("t5 pre r1", 32'h48);
    for (int i = 0; i < 4; i++) push_exp($sformatf("t5 rst r%0d", i), 32'h0);
    push_exp("t5 rst flags", 32'h0);
    push_exp("t5 rst io", 32'h0);
    push_exp("t5 rst pc", 32'h0);
    model_reset();
    model_run(1'b0);
    push_exp("t5 cycles", 32'(m_cycles));
    push_arch("t5");
    do_reset();
    repeat (29) @(posedge clk);
    #1;
    check_obs(32'(dut.regs_q[0]));
    check_obs(32'(dut.regs_q[1]));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) check_obs(32'(dut.regs_q[i]));
    check_obs(32'({dut.flag_n_q, dut.flag_z_q, dut.flag_c_q}));
    check_obs(32'(dut.io_reg_q));
    check_obs(32'(dut.pc_q));
    @(negedge clk);
    rst = 1'b0;
    run_to_halt(cyc, wrapped);
    $display("[TB] t5 restart: %0d cycles to halt", cyc);
    check_obs(32'(cyc));
    check_arch();

    // T2: mixed ALU/store program ending in a taken JMPN.
    prog_q = '{8'h10, 8'h64, 8'h14, 8'h25, 8'h18, 8'h2D, 8'h1C, 8'h00,
               8'h26, 8'h97, 8'h31, 8'h1C, 8'h01, 8'h93, 8'h59, 8'h1C,
               8'h02, 8'h9B, 8'h70, 8'h1C, 8'h03, 8'h93, 8'hE0, 8'h19,
               8'hF0, 8'hBC, 8'h00, 8'hF0};
    load_prog(8'hF0);
    model_reset();
    model_run(1'b0);
    push_exp("t2 cycles", 32'(m_cycles));
    push_arch("t2");
    push_exp("t2 spec r0", 32'hEE);
    push_exp("t2 spec r1", 32'h52);
    push_exp("t2 spec r2", 32'h7F);
    push_exp("t2 spec r3", 32'h03);
    push_exp("t2 io led", 32'hEE);
    push_exp("t2 dmem0", 32'h52);
    push_exp("t2 dmem1", 32'h12);
    push_exp("t2 dmem2", 32'h7F);
    push_exp("t2 dmem3", 32'hEE);
    do_reset();
    run_to_halt(cyc, wrapped);
    $display("[TB] t2 run: %0d cycles to halt", cyc);
    check_obs(32'(cyc));
    check_arch();
    for (int i = 0; i < 4; i++) check_obs(32'(dut.regs_q[i]));
    led_io(v); check_obs(32'(v));
    for (int i = 0; i < 4; i++) begin
      dbg_read(8'(i), v);
      check_obs(32'(v));
    end

    // T6: LED mux priorities with io_reg=EE and dmem[0]=52, dmem[2]=7F.
    push_exp("led none", 32'h00);
    push_exp("led io", 32'hEE);
    push_exp("led both", 32'h52);
    push_exp("led both addr2", 32'h7F);
    @(negedge clk);
    led_driver_flag = 1'b0; rd_addr_flag = 1'b0; rd_addr = 8'h00;
    @(negedge clk); check_obs(32'(led_driver));
    led_driver_flag = 1'b1;
    @(negedge clk); check_obs(32'(led_driver));
    rd_addr_flag = 1'b1;
    @(negedge clk); check_obs(32'(led_driver));
    rd_addr = 8'h02;
    @(negedge clk); check_obs(32'(led_driver));
    rd_addr_flag = 1'b0;
    $display("[TB] t6 led mux checks done");

    // T3a: JMPZ taken on Z from ADD 0+0; JMPN not taken still skips its imm.
    prog_q = '{8'h10, 8'h00, 8'h20, 8'hD0, 8'h07, 8'hF0, 8'hF0,
               8'hE0, 8'h0C, 8'h14, 8'h5A, 8'hF0, 8'hF0};
    load_prog(8'hF0);
    model_reset();
    model_run(1'b0);
    push_exp("t3a cycles", 32'(m_cycles));
    push_arch("t3a");
    push_exp("t3a r1 via fallthrough", 32'h5A);
    do_reset();
    run_to_halt(cyc, wrapped);
    $display("[TB] t3a run: %0d cycles to halt", cyc);
    check_obs(32'(cyc));
    check_arch();
    check_obs(32'(dut.regs_q[1]));

    // T3b: carry_in=1 with FF+00 wraps to 00 with C=1, Z=1.
    prog_q = '{8'h14, 8'hFF, 8'h18, 8'h00, 8'h26, 8'hF0};
    load_prog(8'hF0);
    carry_in = 1'b1;
    model_reset();
    model_run(1'b1);
    push_exp("t3b cycles", 32'(m_cycles));
    push_arch("t3b");
    push_exp("t3b spec r1", 32'h00);
    push_exp("t3b spec c", 32'h1);
    push_exp("t3b spec z", 32'h1);
    do_reset();
    run_to_halt(cyc, wrapped);
    $display("[TB] t3b run: %0d cycles to halt", cyc);
    check_obs(32'(cyc));
    check_arch();
    check_obs(32'(dut.regs_q[1]));
    check_obs(32'(dut.flag_c_q));
    check_obs(32'(dut.flag_z_q));
    carry_in = 1'b0;

    // T4: NOOP sled F0..FF wraps PC to 00, then BRK holds state for 100 cycles.
    prog_q = '{8'hE0, 8'h10, 8'h14, 8'h80, 8'h21, 8'hC0, 8'hF0};
    load_prog(8'h00);
    dut.imem_mem[8'h10] = 8'hF0;
    rom[8'h10] = 8'hF0;
    model_reset();
    model_run(1'b0);
    push_exp("t4 cycles", 32'(m_cycles));
    push_exp("t4 pc wrap seen", 32'h1);
    push_arch("t4");
    push_arch("t4 frozen");
    do_reset();
    run_to_halt(cyc, wrapped);
    $display("[TB] t4 run: %0d cycles to halt, wrap=%0d", cyc, wrapped);
    check_obs(32'(cyc));
    check_obs(32'(wrapped));
    check_arch();
    repeat (100) @(posedge clk);
    #1;
    check_arch();

    if (sb_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard_leftover: observed %0d expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
